// File: rtl/seq_signed_divider.sv
// seq_signed_divider
//   Sequential two's-complement divider. The operand magnitudes go through
//   an unsigned restoring divider, one quotient bit per clock, and the signs
//   are applied in a final fix-up cycle. Latency is WIDTH+1 clocks from the
//   accepting edge, whatever the operands are.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset; aborts a running division
//   start       request, sampled only while busy=0
//   dividend    signed dividend, sampled on the accepting edge
//   divisor     signed divisor, sampled on the accepting edge
//   busy        high while a division is in progress
//   done        one-cycle pulse when the result registers are written
//   quotient    signed quotient, truncated toward zero
//   remainder   signed remainder, sign follows the dividend
//   div_by_zero the last result had a zero divisor
//   overflow    the last result was most-negative / -1 (quotient wraps)
module seq_signed_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned    CW       = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             sa_q, sb_q, dbz_q, ovf_q;

    logic [WIDTH-1:0] rem_d, quo_d;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic [WIDTH:0]   shifted, trial;
    logic             is_zero, is_ovf;

    always_comb begin
        // |most-negative| = 2^(WIDTH-1) is still exact as an unsigned WIDTH-bit value
        a_abs   = dividend[WIDTH-1] ? -dividend : dividend;
        b_abs   = divisor[WIDTH-1]  ? -divisor  : divisor;
        is_zero = (divisor == '0);
        is_ovf  = (dividend == MOST_NEG) && (divisor == '1);

        // One restoring step: shift {rem,quo} left, try subtracting the divisor.
        // A set MSB of the WIDTH+1-bit trial means the subtraction went negative.
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end

        // With a zero divisor every trial succeeds, so the magnitude remainder
        // already equals |dividend|; only the quotient needs forcing to all ones.
        q_fix = dbz_q ? '1 : ((sa_q ^ sb_q) ? -quo_q : quo_q);
        r_fix = sa_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_q   <= '0;
                        quo_q   <= a_abs;
                        dvs_q   <= b_abs;
                        sa_q    <= dividend[WIDTH-1];
                        sb_q    <= divisor[WIDTH-1];
                        dbz_q   <= is_zero;
                        ovf_q   <= is_ovf;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quotient    <= q_fix;
                    remainder   <= r_fix;
                    div_by_zero <= dbz_q;
                    overflow    <= ovf_q;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider
//   Directed and swept stimulus for seq_signed_divider (WIDTH=8). Expected
//   results are queued when a division is started and popped by a monitor
//   whenever done pulses.
module tb_seq_signed_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done, div_by_zero, overflow;
    logic [7:0] quotient, remainder;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    seq_signed_divider #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] q, input logic [7:0] r,
                                input logic dbz, input logic ovf);
        exp_t e;
        e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf;
        return e;
    endfunction

    // Reference from the language's truncating signed / and %.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int ia, ib;
        ia = $signed(a);
        ib = $signed(b);
        if (b == 8'h00) begin
            e = mk(8'hFF, a, 1'b1, 1'b0);
        end else begin
            e = mk(8'(ia / ib), 8'(ia % ib), 1'b0, (a == 8'h80) && (b == 8'hFF));
        end
        return e;
    endfunction

    // Result monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            chk("done_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient",    32'(quotient),    32'(e.q));
                chk("remainder",   32'(remainder),   32'(e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                chk("overflow",    32'(overflow),    32'(e.ovf));
            end
        end
    end

    // One division: latency and busy width are checked here, results by the monitor.
    // A nonzero stray value pulses start with other operands at that busy cycle.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, input exp_t e,
                           input int stray);
        int cnt, busy_cnt;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        dividend = 8'($urandom); divisor = 8'($urandom);
        cnt = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && cnt < 30) begin
            start = (cnt == stray) ? 1'b1 : 1'b0;
            @(negedge clk);
            cnt++;
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        chk("latency_edges", 32'(cnt - 1), 32'd9);
        chk("busy_cycles",   32'(busy_cnt), 32'd9);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, done_cnt;
        logic [7:0] dv [8];
        dv = '{8'd0, 8'd1, 8'hFF, 8'd2, 8'hFE, 8'd7, 8'd127, 8'h80};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            32'({busy, done, quotient, remainder, div_by_zero, overflow}), 32'd0);
        rst = 1'b0;

        // Basic and sign combinations
        run_div(8'd100, 8'd7,   mk(8'd14,  8'd2,  1'b0, 1'b0), 0);
        run_div(8'h9C,  8'd7,   mk(8'hF2,  8'hFE, 1'b0, 1'b0), 0);
        run_div(8'd100, 8'hF9,  mk(8'hF2,  8'd2,  1'b0, 1'b0), 0);
        run_div(8'h9C,  8'hF9,  mk(8'd14,  8'hFE, 1'b0, 1'b0), 0);

        // Most-negative boundaries
        run_div(8'h80,  8'hFF,  mk(8'h80,  8'd0,  1'b0, 1'b1), 0);
        run_div(8'h80,  8'd1,   mk(8'h80,  8'd0,  1'b0, 1'b0), 0);
        run_div(8'd127, 8'h80,  mk(8'd0,   8'd127, 1'b0, 1'b0), 0);

        // Divide by zero, then a normal result clears the flag
        run_div(8'd37,  8'd0,   mk(8'hFF,  8'h25, 1'b1, 1'b0), 0);
        run_div(8'd9,   8'd3,   mk(8'd3,   8'd0,  1'b0, 1'b0), 0);

        // Start pulse during busy is ignored
        run_div(8'd77,  8'd6,   mk(8'd12,  8'd5,  1'b0, 1'b0), 4);

        // Start held high: back-to-back results, operands disturbed mid-division
        @(negedge clk);
        start = 1'b1; dividend = 8'd20; divisor = 8'd3;
        sb.push_back(mk(8'd6, 8'd2, 1'b0, 1'b0));
        for (int rnd = 0; rnd < 3; rnd++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
                if (cnt == 4) begin dividend = 8'd99; divisor = 8'd5; end
                if (cnt == 8) begin dividend = 8'd20; divisor = 8'd3; end
            end while (!done && cnt < 30);
            chk("b2b_done_interval", 32'(cnt), 32'd10);
            if (rnd < 2) sb.push_back(mk(8'd6, 8'd2, 1'b0, 1'b0));
            else start = 1'b0;
        end

        // Reset in the middle of 50/5: outputs clear, no done, then a clean rerun
        @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs",
            32'({busy, done, quotient, remainder, div_by_zero, overflow}), 32'd0);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        run_div(8'd50, 8'd5, mk(8'd10, 8'd0, 1'b0, 1'b0), 0);

        // Every dividend against boundary divisors, then random pairs
        for (int a = 0; a < 256; a++) begin
            for (int k = 0; k < 8; k++) begin
                run_div(8'(a), dv[k], model(8'(a), dv[k]), 0);
            end
        end
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_div(ra, rb, model(ra, rb), 0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
